sd_host_reg_bank: RTL and testbench

SD_HOST_REG_BANK -- requirements
Module: sd_host_reg_bank

---
 rtl/sd_host_pkg.sv | 72 +++++++
 rtl/sd_w1c_status.sv | 51 +++++
 rtl/sd_host_reg_bank.sv | 211 +++++++++++++++++++++
 tb/tb_sd_host_reg_bank.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_host_pkg.sv
// Shared offsets, reset values and interrupt bit indices for the SD host register bank.
package sd_host_pkg;

    // Register byte offsets
    localparam int unsigned OFF_BLK     = 'h004;  // BSR[15:0], BCR[31:16]
    localparam int unsigned OFF_ARG     = 'h008;
    localparam int unsigned OFF_CMD     = 'h00C;  // TMR[15:0], CR[31:16]
    localparam int unsigned OFF_RESP    = 'h010;
    localparam int unsigned OFF_PSR     = 'h024;
    localparam int unsigned OFF_ISR     = 'h030;  // NISR[15:0], EISR[31:16]
    localparam int unsigned OFF_IE      = 'h034;  // NIE[15:0], EIE[31:16]
    localparam int unsigned OFF_ADMA_LO = 'h058;
    localparam int unsigned OFF_ADMA_HI = 'h05C;

    // Reset values
    localparam logic [15:0] RST_BSR  = 16'h0000;
    localparam logic [15:0] RST_BCR  = 16'h0000;
    localparam logic [31:0] RST_ARG  = 32'h0000_0000;
    localparam logic [15:0] RST_TMR  = 16'h0000;
    localparam logic [15:0] RST_CR   = 16'h0000;
    localparam logic [31:0] RST_RESP = 32'h0000_0000;
    localparam logic [15:0] RST_ISR  = 16'h0000;
    localparam logic [15:0] RST_IE   = 16'h0000;
    localparam logic [63:0] RST_ADMA = 64'h0;

    // Present-state bits
    localparam int unsigned PSR_CMD_INHIBIT = 0;
    localparam int unsigned PSR_DAT_INHIBIT = 1;

    // Normal interrupt status bits
    localparam int unsigned NISR_CMD_COMPLETE  = 0;
    localparam int unsigned NISR_XFER_COMPLETE = 1;
    localparam int unsigned NISR_BUF_WR_READY  = 4;
    localparam int unsigned NISR_BUF_RD_READY  = 5;
    localparam int unsigned NISR_CARD_INS      = 6;
    localparam int unsigned NISR_CARD_REM      = 7;
    localparam int unsigned NISR_CARD_INT      = 8;
    localparam int unsigned NISR_ERR_INT       = 15;

    // Error interrupt status bits
    localparam int unsigned EISR_CMD_TIMEOUT = 0;
    localparam int unsigned EISR_CMD_CRC     = 1;
    localparam int unsigned EISR_CMD_END_BIT = 2;
    localparam int unsigned EISR_CMD_INDEX   = 3;
    localparam int unsigned EISR_DAT_TIMEOUT = 4;
    localparam int unsigned EISR_DAT_CRC     = 5;
    localparam int unsigned EISR_DAT_END_BIT = 6;
    localparam int unsigned EISR_ADMA        = 9;

    typedef enum logic [3:0] {
        RegNone,
        RegBlk,
        RegArg,
        RegCmd,
        RegResp,
        RegPsr,
        RegIsr,
        RegIe,
        RegAdmaLo,
        RegAdmaHi
    } reg_sel_e;

    // Replace only the byte lanes whose enable is set
    function automatic logic [31:0] merge_lanes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  be);
        logic [31:0] mask;
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (old_val & ~mask) | (new_val & mask);
    endfunction

endpackage

// File: rtl/sd_w1c_status.sv
// Write-1-to-clear interrupt status register with its enable register and irq term.
module sd_w1c_status
    import sd_host_pkg::*;
#(
    parameter int unsigned NIRQ = 16
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic [NIRQ-1:0] set_i,
    input  logic            sts_wr_i,
    input  logic            en_wr_i,
    input  logic [1:0]      be_i,
    input  logic [15:0]     wdata_i,
    output logic [NIRQ-1:0] status_o,
    output logic [NIRQ-1:0] enable_o,
    output logic            irq_term_o
);

    logic [15:0]     lane_mask;
    logic [NIRQ-1:0] clr;
    logic [NIRQ-1:0] status_q, status_d;
    logic [NIRQ-1:0] enable_q, enable_d;

    // Next state: set pulses override a same-cycle clear
    always_comb begin
        lane_mask = {{8{be_i[1]}}, {8{be_i[0]}}};
        clr       = sts_wr_i ? (wdata_i[NIRQ-1:0] & lane_mask[NIRQ-1:0]) : '0;
        status_d  = (status_q & ~clr) | set_i;
        enable_d  = enable_q;
        if (en_wr_i) begin
            enable_d = (enable_q & ~lane_mask[NIRQ-1:0]) |
                       (wdata_i[NIRQ-1:0] & lane_mask[NIRQ-1:0]);
        end
    end

    // Status and enable flops
    always_ff @(posedge CLK) begin
        if (RESET) begin
            status_q <= RST_ISR[NIRQ-1:0];
            enable_q <= RST_IE[NIRQ-1:0];
        end else begin
            status_q <= status_d;
            enable_q <= enable_d;
        end
    end

    assign status_o   = status_q;
    assign enable_o   = enable_q;
    assign irq_term_o = |(status_q & enable_q);

endmodule

// File: rtl/sd_host_reg_bank.sv
// SD host controller CPU register bank: decode, byte-lane writes, registered reads, status/irq.
module sd_host_reg_bank
    import sd_host_pkg::*;
#(
    parameter int unsigned ADDR_W  = 12,
    parameter int unsigned ADMA_AW = 64,
    parameter int unsigned NIRQ    = 16
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic [ADDR_W-1:0]  reg_address,
    input  logic [31:0]        reg_wr_data,
    input  logic               reg_wr_en,
    input  logic [3:0]         reg_byte_en,
    input  logic               reg_rd_en,
    output logic [31:0]        reg_rd_data,
    output logic               reg_rd_valid,
    input  logic [31:0]        psr_in,
    input  logic [15:0]        nisr_set,
    input  logic [15:0]        eisr_set,
    input  logic [31:0]        resp_in,
    input  logic               resp_wr_en,
    input  logic               blk_cnt_dec,
    output logic [31:0]        arg_o,
    output logic [15:0]        tmr_o,
    output logic [15:0]        cr_o,
    output logic [15:0]        bsr_o,
    output logic [15:0]        bcr_o,
    output logic [ADMA_AW-1:0] adma_addr_o,
    output logic               start_flag,
    output logic               irq
);

    reg_sel_e sel;

    logic [15:0]        bsr_q, bsr_d, bcr_q, bcr_d;
    logic [31:0]        arg_q, arg_d;
    logic [15:0]        tmr_q, tmr_d, cr_q, cr_d;
    logic [31:0]        resp_q, resp_d;
    logic [ADMA_AW-1:0] adma_q, adma_d;
    logic [63:0]        adma_ext_q, adma_ext_d;
    logic [31:0]        rd_data_q, rd_data_d;
    logic               rd_valid_q, rd_valid_d;
    logic               start_q, start_d;
    logic               irq_q, irq_d;

    logic [31:0]        merged_blk, merged_cmd, read_word;
    logic               wr_isr, wr_ie;
    logic [NIRQ-1:0]    nisr_q, nie_q, eisr_q, eie_q;
    logic               nisr_term, eisr_term;

    // Address decode; the upper ADMA word exists only in 64-bit builds
    always_comb begin
        sel = RegNone;
        if (reg_address == ADDR_W'(OFF_BLK))          sel = RegBlk;
        else if (reg_address == ADDR_W'(OFF_ARG))     sel = RegArg;
        else if (reg_address == ADDR_W'(OFF_CMD))     sel = RegCmd;
        else if (reg_address == ADDR_W'(OFF_RESP))    sel = RegResp;
        else if (reg_address == ADDR_W'(OFF_PSR))     sel = RegPsr;
        else if (reg_address == ADDR_W'(OFF_ISR))     sel = RegIsr;
        else if (reg_address == ADDR_W'(OFF_IE))      sel = RegIe;
        else if (reg_address == ADDR_W'(OFF_ADMA_LO)) sel = RegAdmaLo;
        else if (ADMA_AW == 64 && reg_address == ADDR_W'(OFF_ADMA_HI)) sel = RegAdmaHi;
    end

    assign adma_ext_q = 64'(adma_q);

    // Read mux over pre-write state, so a same-cycle write never leaks into the read
    always_comb begin
        read_word = '0;
        unique case (sel)
            RegBlk:    read_word = {bcr_q, bsr_q};
            RegArg:    read_word = arg_q;
            RegCmd:    read_word = {cr_q, tmr_q};
            RegResp:   read_word = resp_q;
            RegPsr:    read_word = psr_in;
            RegIsr:    read_word = {16'(eisr_q), 16'(nisr_q)};
            RegIe:     read_word = {16'(eie_q), 16'(nie_q)};
            RegAdmaLo: read_word = adma_ext_q[31:0];
            RegAdmaHi: read_word = adma_ext_q[63:32];
            default:   read_word = '0;
        endcase
        rd_valid_d = reg_rd_en;
        rd_data_d  = reg_rd_en ? read_word : '0;
    end

    // Register write next-state, block-count decrement and start pulse
    always_comb begin
        merged_blk = merge_lanes({bcr_q, bsr_q}, reg_wr_data, reg_byte_en);
        merged_cmd = merge_lanes({cr_q, tmr_q}, reg_wr_data, reg_byte_en);
        bsr_d      = bsr_q;
        bcr_d      = bcr_q;
        arg_d      = arg_q;
        tmr_d      = tmr_q;
        cr_d       = cr_q;
        resp_d     = resp_q;
        adma_ext_d = adma_ext_q;
        start_d    = 1'b0;

        if (reg_wr_en && sel == RegBlk) begin
            bsr_d = merged_blk[15:0];
        end
        // A CPU write to the count lanes wins over the decrement
        if (reg_wr_en && sel == RegBlk && (reg_byte_en[3] || reg_byte_en[2])) begin
            bcr_d = merged_blk[31:16];
        end else if (blk_cnt_dec && bcr_q != 16'h0) begin
            bcr_d = bcr_q - 16'h1;
        end

        if (reg_wr_en && sel == RegArg) begin
            arg_d = merge_lanes(arg_q, reg_wr_data, reg_byte_en);
        end

        if (reg_wr_en && sel == RegCmd) begin
            tmr_d = merged_cmd[15:0];
            // Command lanes are locked out while the CMD line is busy
            if (!psr_in[PSR_CMD_INHIBIT]) begin
                cr_d    = merged_cmd[31:16];
                start_d = reg_byte_en[3];
            end
        end

        if (resp_wr_en) begin
            resp_d = resp_in;
        end

        if (reg_wr_en && sel == RegAdmaLo) begin
            adma_ext_d[31:0] = merge_lanes(adma_ext_q[31:0], reg_wr_data, reg_byte_en);
        end
        if (reg_wr_en && sel == RegAdmaHi) begin
            adma_ext_d[63:32] = merge_lanes(adma_ext_q[63:32], reg_wr_data, reg_byte_en);
        end
        adma_d = adma_ext_d[ADMA_AW-1:0];

        irq_d = nisr_term | eisr_term;
    end

    assign wr_isr = reg_wr_en && sel == RegIsr;
    assign wr_ie  = reg_wr_en && sel == RegIe;

    sd_w1c_status #(
        .NIRQ (NIRQ)
    ) u_nisr (
        .CLK        (CLK),
        .RESET      (RESET),
        .set_i      (nisr_set[NIRQ-1:0]),
        .sts_wr_i   (wr_isr),
        .en_wr_i    (wr_ie),
        .be_i       (reg_byte_en[1:0]),
        .wdata_i    (reg_wr_data[15:0]),
        .status_o   (nisr_q),
        .enable_o   (nie_q),
        .irq_term_o (nisr_term)
    );

    sd_w1c_status #(
        .NIRQ (NIRQ)
    ) u_eisr (
        .CLK        (CLK),
        .RESET      (RESET),
        .set_i      (eisr_set[NIRQ-1:0]),
        .sts_wr_i   (wr_isr),
        .en_wr_i    (wr_ie),
        .be_i       (reg_byte_en[3:2]),
        .wdata_i    (reg_wr_data[31:16]),
        .status_o   (eisr_q),
        .enable_o   (eie_q),
        .irq_term_o (eisr_term)
    );

    // Register state; reset also discards any access issued in the same cycle
    always_ff @(posedge CLK) begin
        if (RESET) begin
            bsr_q      <= RST_BSR;
            bcr_q      <= RST_BCR;
            arg_q      <= RST_ARG;
            tmr_q      <= RST_TMR;
            cr_q       <= RST_CR;
            resp_q     <= RST_RESP;
            adma_q     <= RST_ADMA[ADMA_AW-1:0];
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            start_q    <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            bsr_q      <= bsr_d;
            bcr_q      <= bcr_d;
            arg_q      <= arg_d;
            tmr_q      <= tmr_d;
            cr_q       <= cr_d;
            resp_q     <= resp_d;
            adma_q     <= adma_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            start_q    <= start_d;
            irq_q      <= irq_d;
        end
    end

    assign reg_rd_data  = rd_data_q;
    assign reg_rd_valid = rd_valid_q;
    assign arg_o        = arg_q;
    assign tmr_o        = tmr_q;
    assign cr_o         = cr_q;
    assign bsr_o        = bsr_q;
    assign bcr_o        = bcr_q;
    assign adma_addr_o  = adma_q;
    assign start_flag   = start_q;
    assign irq          = irq_q;

endmodule

// File: tb/tb_sd_host_reg_bank.sv
// Self-checking bench: per-cycle behavioural model plus directed literal checks.
module tb_sd_host_reg_bank;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [11:0] reg_address;
    logic [31:0] reg_wr_data;
    logic        reg_wr_en;
    logic [3:0]  reg_byte_en;
    logic        reg_rd_en;
    logic [31:0] psr_in;
    logic [15:0] nisr_set, eisr_set;
    logic [31:0] resp_in;
    logic        resp_wr_en;
    logic        blk_cnt_dec;

    logic [31:0] rd_data, rd_data_32;
    logic        rd_valid, rd_valid_32;
    logic [31:0] arg_o, arg_32;
    logic [15:0] tmr_o, cr_o, bsr_o, bcr_o, tmr_32, cr_32, bsr_32, bcr_32;
    logic [63:0] adma_o;
    logic [31:0] adma_32;
    logic        start_o, irq_o, start_32, irq_32;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    sd_host_reg_bank dut (
        .CLK(CLK), .RESET(RESET), .reg_address(reg_address), .reg_wr_data(reg_wr_data),
        .reg_wr_en(reg_wr_en), .reg_byte_en(reg_byte_en), .reg_rd_en(reg_rd_en),
        .reg_rd_data(rd_data), .reg_rd_valid(rd_valid), .psr_in(psr_in),
        .nisr_set(nisr_set), .eisr_set(eisr_set), .resp_in(resp_in),
        .resp_wr_en(resp_wr_en), .blk_cnt_dec(blk_cnt_dec), .arg_o(arg_o), .tmr_o(tmr_o),
        .cr_o(cr_o), .bsr_o(bsr_o), .bcr_o(bcr_o), .adma_addr_o(adma_o),
        .start_flag(start_o), .irq(irq_o)
    );

    sd_host_reg_bank #(.ADMA_AW(32)) dut32 (
        .CLK(CLK), .RESET(RESET), .reg_address(reg_address), .reg_wr_data(reg_wr_data),
        .reg_wr_en(reg_wr_en), .reg_byte_en(reg_byte_en), .reg_rd_en(reg_rd_en),
        .reg_rd_data(rd_data_32), .reg_rd_valid(rd_valid_32), .psr_in(psr_in),
        .nisr_set(nisr_set), .eisr_set(eisr_set), .resp_in(resp_in),
        .resp_wr_en(resp_wr_en), .blk_cnt_dec(blk_cnt_dec), .arg_o(arg_32), .tmr_o(tmr_32),
        .cr_o(cr_32), .bsr_o(bsr_32), .bcr_o(bcr_32), .adma_addr_o(adma_32),
        .start_flag(start_32), .irq(irq_32)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_arg, m_resp, m_rd_data, m_rd_data32;
    logic [15:0] m_bsr, m_bcr, m_tmr, m_cr, m_nisr, m_eisr, m_nie, m_eie;
    logic [63:0] m_adma;
    logic        m_rd_valid, m_start, m_irq;

    function automatic logic [31:0] put_bytes(input logic [31:0] old_v, input logic [31:0] new_v,
                                              input logic [3:0] be);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_read(input logic [11:0] a, input bit aw32);
        case (a)
            12'h004: return {m_bcr, m_bsr};
            12'h008: return m_arg;
            12'h00C: return {m_cr, m_tmr};
            12'h010: return m_resp;
            12'h024: return psr_in;
            12'h030: return {m_eisr, m_nisr};
            12'h034: return {m_eie, m_nie};
            12'h058: return m_adma[31:0];
            12'h05C: return aw32 ? 32'h0 : m_adma[63:32];
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_arg = 0; m_resp = 0; m_rd_data = 0; m_rd_data32 = 0; m_bsr = 0; m_bcr = 0;
        m_tmr = 0; m_cr = 0; m_nisr = 0; m_eisr = 0; m_nie = 0; m_eie = 0; m_adma = 0;
        m_rd_valid = 0; m_start = 0; m_irq = 0;
    endtask

    task automatic model_step();
        logic [31:0] w, clr;
        logic        wr_blk_count;
        // Outputs derived from state before this edge
        m_rd_valid  = reg_rd_en;
        m_rd_data   = reg_rd_en ? model_read(reg_address, 1'b0) : 32'h0;
        m_rd_data32 = reg_rd_en ? model_read(reg_address, 1'b1) : 32'h0;
        m_start     = reg_wr_en && reg_address == 12'h00C && reg_byte_en[3] && !psr_in[0];
        m_irq       = ((m_nisr & m_nie) != 0) || ((m_eisr & m_eie) != 0);
        // Status: clear first, then set so that set wins
        clr = 32'h0;
        if (reg_wr_en && reg_address == 12'h030) clr = put_bytes(32'h0, reg_wr_data, reg_byte_en);
        m_nisr = (m_nisr & ~clr[15:0]) | nisr_set;
        m_eisr = (m_eisr & ~clr[31:16]) | eisr_set;
        wr_blk_count = reg_wr_en && reg_address == 12'h004 && (reg_byte_en[3:2] != 0);
        if (reg_wr_en) begin
            case (reg_address)
                12'h004: begin
                    w = put_bytes({m_bcr, m_bsr}, reg_wr_data, reg_byte_en);
                    m_bsr = w[15:0];
                    m_bcr = w[31:16];
                end
                12'h008: m_arg = put_bytes(m_arg, reg_wr_data, reg_byte_en);
                12'h00C: begin
                    w = put_bytes({m_cr, m_tmr}, reg_wr_data, reg_byte_en);
                    m_tmr = w[15:0];
                    if (!psr_in[0]) m_cr = w[31:16];
                end
                12'h034: begin
                    w = put_bytes({m_eie, m_nie}, reg_wr_data, reg_byte_en);
                    m_nie = w[15:0];
                    m_eie = w[31:16];
                end
                12'h058: m_adma[31:0]  = put_bytes(m_adma[31:0], reg_wr_data, reg_byte_en);
                12'h05C: m_adma[63:32] = put_bytes(m_adma[63:32], reg_wr_data, reg_byte_en);
                default: ;
            endcase
        end
        if (!wr_blk_count && blk_cnt_dec && m_bcr > 0) m_bcr = m_bcr - 1;
        if (resp_wr_en) m_resp = resp_in;
    endtask

    // Model advances on each edge; outputs compared 1 time unit later
    always @(posedge CLK) begin
        if (RESET) model_reset();
        else model_step();
        #1;
        chk("m_rd_valid", 64'(rd_valid), 64'(m_rd_valid));
        chk("m_rd_data", 64'(rd_data), 64'(m_rd_data));
        chk("m_rd_data32", 64'(rd_data_32), 64'(m_rd_data32));
        chk("m_arg", 64'(arg_o), 64'(m_arg));
        chk("m_tmr", 64'(tmr_o), 64'(m_tmr));
        chk("m_cr", 64'(cr_o), 64'(m_cr));
        chk("m_bsr", 64'(bsr_o), 64'(m_bsr));
        chk("m_bcr", 64'(bcr_o), 64'(m_bcr));
        chk("m_adma", adma_o, m_adma);
        chk("m_adma32", 64'(adma_32), 64'(m_adma[31:0]));
        chk("m_start", 64'(start_o), 64'(m_start));
        chk("m_irq", 64'(irq_o), 64'(m_irq));
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc();
        @(negedge CLK);
    endtask

    task automatic idle();
        reg_wr_en = 0; reg_rd_en = 0; reg_byte_en = 0; reg_wr_data = 0; reg_address = 0;
        nisr_set = 0; eisr_set = 0; resp_wr_en = 0; blk_cnt_dec = 0;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] be);
        reg_address = a; reg_wr_data = d; reg_byte_en = be; reg_wr_en = 1;
        cyc();
        idle();
    endtask

    task automatic rd(input logic [11:0] a);
        reg_address = a; reg_rd_en = 1;
        cyc();
        idle();
    endtask

    initial begin
        RESET = 1; psr_in = 0; resp_in = 0;
        idle();
        repeat (3) cyc();
        chk("rst_arg", 64'(arg_o), 64'h0);
        chk("rst_cr", 64'(cr_o), 64'h0);
        chk("rst_valid", 64'(rd_valid), 64'h0);
        chk("rst_irq", 64'(irq_o), 64'h0);
        RESET = 0;
        cyc();

        // Command write with CMD line free
        wr(12'h00C, 32'h0C1A_0020, 4'hF);
        chk("cmd_cr", 64'(cr_o), 64'h0C1A);
        chk("cmd_tmr", 64'(tmr_o), 64'h0020);
        chk("cmd_start_hi", 64'(start_o), 64'h1);
        cyc();
        chk("cmd_start_lo", 64'(start_o), 64'h0);

        RESET = 1; cyc(); RESET = 0;

        // Command write while CMD inhibit is set
        psr_in = 32'h1;
        wr(12'h00C, 32'h0C1A_0020, 4'hF);
        chk("inh_cr", 64'(cr_o), 64'h0);
        chk("inh_tmr", 64'(tmr_o), 64'h0020);
        chk("inh_start", 64'(start_o), 64'h0);
        psr_in = 32'h0;
        cyc();

        // Normal interrupt set / clear / set-wins
        wr(12'h034, 32'h0000_0001, 4'hF);
        nisr_set = 16'h0001; cyc(); idle();
        cyc();
        chk("irq_set", 64'(irq_o), 64'h1);
        wr(12'h030, 32'h0000_0001, 4'hF);
        cyc();
        chk("irq_clr", 64'(irq_o), 64'h0);
        nisr_set = 16'h0001;
        wr(12'h030, 32'h0000_0001, 4'hF);
        rd(12'h030);
        chk("set_wins", 64'(rd_data), 64'h1);
        wr(12'h030, 32'h0000_0001, 4'hF);

        // Error interrupt, and a clear with its lanes disabled
        wr(12'h034, 32'h0010_0000, 4'hC);
        eisr_set = 16'h0010; cyc(); idle();
        wr(12'h030, 32'h0010_0000, 4'h3);
        cyc();
        chk("eirq", 64'(irq_o), 64'h1);
        rd(12'h030);
        chk("eisr_kept", 64'(rd_data), 64'h0010_0000);

        // Block count decrement with saturation
        wr(12'h004, 32'h0002_0200, 4'hF);
        chk("bcr_load", 64'(bcr_o), 64'h2);
        chk("bsr_load", 64'(bsr_o), 64'h200);
        blk_cnt_dec = 1;
        cyc(); chk("bcr_dec1", 64'(bcr_o), 64'h1);
        cyc(); chk("bcr_dec0", 64'(bcr_o), 64'h0);
        cyc(); chk("bcr_sat", 64'(bcr_o), 64'h0);
        wr(12'h004, 32'h0005_0000, 4'hC);
        chk("bcr_cpu_wins", 64'(bcr_o), 64'h5);
        chk("bsr_kept", 64'(bsr_o), 64'h200);

        // Byte-lane write and registered reads
        wr(12'h008, 32'hDEAD_BEEF, 4'h3);
        chk("arg_lanes", 64'(arg_o), 64'h0000_BEEF);
        rd(12'h008);
        chk("rd_valid", 64'(rd_valid), 64'h1);
        chk("rd_arg", 64'(rd_data), 64'h0000_BEEF);
        cyc();
        chk("rd_valid_lo", 64'(rd_valid), 64'h0);
        rd(12'h100);
        chk("rd_unmapped", 64'(rd_data), 64'h0);
        chk("rd_unmapped_v", 64'(rd_valid), 64'h1);

        // Same-cycle read and write: read sees the old value
        reg_rd_en = 1;
        wr(12'h008, 32'hCAFE_F00D, 4'hF);
        chk("rw_old", 64'(rd_data), 64'h0000_BEEF);
        chk("rw_new", 64'(arg_o), 64'hCAFE_F00D);

        // ADMA address, 64-bit and 32-bit builds
        wr(12'h058, 32'h1122_3344, 4'hF);
        wr(12'h05C, 32'h5566_7788, 4'hF);
        chk("adma64", adma_o, 64'h5566_7788_1122_3344);
        chk("adma32", 64'(adma_32), 64'h1122_3344);
        rd(12'h05C);
        chk("rd_adma_hi64", 64'(rd_data), 64'h5566_7788);
        chk("rd_adma_hi32", 64'(rd_data_32), 64'h0);

        // Response load, read-only response and present state
        resp_in = 32'hA5A5_0F0F; resp_wr_en = 1; cyc(); idle();
        wr(12'h010, 32'h1234_5678, 4'hF);
        rd(12'h010);
        chk("rd_resp", 64'(rd_data), 64'hA5A5_0F0F);
        psr_in = 32'h0000_0002;
        rd(12'h024);
        chk("rd_psr", 64'(rd_data), 64'h2);
        psr_in = 32'h0;

        // Reset in mid-transfer, with a read and write in the same cycle
        wr(12'h004, 32'h0003_0000, 4'hC);
        blk_cnt_dec = 1; cyc(); idle();
        RESET = 1; reg_rd_en = 1;
        wr(12'h00C, 32'h0C1A_0020, 4'hF);
        RESET = 0;
        chk("mid_bcr", 64'(bcr_o), 64'h0);
        chk("mid_start", 64'(start_o), 64'h0);
        chk("mid_valid", 64'(rd_valid), 64'h0);
        chk("mid_adma", adma_o, 64'h0);
        chk("mid_irq", 64'(irq_o), 64'h0);
        blk_cnt_dec = 1; cyc(); idle();
        chk("post_rst_dec", 64'(bcr_o), 64'h0);
        cyc();
        chk("post_rst_start", 64'(start_o), 64'h0);

        repeat (3) cyc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
